// File: rtl/clean_countdown_display_if.sv
// Signal bundle between the self-clean controller (master) and the countdown display stage (slave).
interface clean_countdown_display_if;
  logic       cleaning;
  logic       done;
  logic [7:0] countdown;
  logic [7:0] seg_out;
  logic [3:0] seg_en;
  logic       conv_busy;

  modport master (
    output cleaning, done, countdown,
    input  seg_out, seg_en, conv_busy
  );

  modport slave (
    input  cleaning, done, countdown,
    output seg_out, seg_en, conv_busy
  );
endinterface

// File: rtl/clean_countdown_display.sv
// Countdown display stage: seconds -> MM:SS BCD by repeated subtraction, 4-digit multiplexed 7-seg drive.
// Optional build macro COLON_BLINK_EN makes the ACTIVE-mode colon blink at 1 Hz instead of staying lit.
//
// state     | meaning
// ST_IDLE   | waiting for countdown to differ from the last converted value
// ST_DIV60  | subtracting 60 per cycle to extract minutes
// ST_DIV10  | subtracting 10 per cycle to extract seconds tens, remainder is seconds ones
// ST_LOAD   | committing all digits to the display registers in one cycle
module clean_countdown_display #(
  parameter int CLK_FREQ = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2,
  parameter int DONE_SEC = 3
) (
  input logic clk,
  input logic rst,
  clean_countdown_display_if.slave bus
);

  localparam int SCAN_DIV   = CLK_FREQ / SCAN_HZ;
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DONE_CYC   = DONE_SEC * CLK_FREQ;
  localparam int DONE_W     = (DONE_CYC > 1) ? $clog2(DONE_CYC) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIV60 = 2'd1;
  localparam logic [1:0] ST_DIV10 = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  logic       cleaning_q, cleaning_d;
  logic       done_q, done_d;
  logic [7:0] countdown_q;
  logic       cleaning_rise, done_rise;

  logic [1:0] state;
  logic [7:0] work;
  logic [7:0] conv_val;
  logic [7:0] last_val;
  logic [2:0] min_acc;
  logic [2:0] sec_t_acc;
  logic [3:0] sec_o_acc;
  logic       busy;

  logic [3:0] disp_min_t, disp_min_o, disp_sec_t, disp_sec_o;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic               done_active;
  logic [DONE_W-1:0]  done_cnt;
  logic               blink_on;
  logic [BLINK_W-1:0] blink_cnt;
  logic               colon_lit;

  logic [3:0] digit_val;
  logic       dp_val;
  logic [7:0] seg_nxt;
  logic [3:0] en_nxt;
  logic [7:0] seg_q;
  logic [3:0] en_q;

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 8'hFC;
      4'd1:    enc = 8'h60;
      4'd2:    enc = 8'hDA;
      4'd3:    enc = 8'hF2;
      4'd4:    enc = 8'h66;
      4'd5:    enc = 8'hB6;
      4'd6:    enc = 8'hBE;
      4'd7:    enc = 8'hE0;
      4'd8:    enc = 8'hFE;
      4'd9:    enc = 8'hF6;
      default: enc = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      cleaning_q  <= 1'b0;
      cleaning_d  <= 1'b0;
      done_q      <= 1'b0;
      done_d      <= 1'b0;
      countdown_q <= 8'd0;
    end else begin
      cleaning_q  <= bus.cleaning;
      cleaning_d  <= cleaning_q;
      done_q      <= bus.done;
      done_d      <= done_q;
      countdown_q <= bus.countdown;
    end
  end

  assign cleaning_rise = cleaning_q & ~cleaning_d;
  assign done_rise     = done_q & ~done_d;

  // Display registers only change in ST_LOAD, so a partial result is never shown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      work       <= 8'd0;
      conv_val   <= 8'd0;
      last_val   <= 8'd0;
      min_acc    <= 3'd0;
      sec_t_acc  <= 3'd0;
      sec_o_acc  <= 4'd0;
      busy       <= 1'b0;
      disp_min_t <= 4'd0;
      disp_min_o <= 4'd0;
      disp_sec_t <= 4'd0;
      disp_sec_o <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (countdown_q != last_val) begin
            work     <= countdown_q;
            conv_val <= countdown_q;
            min_acc  <= 3'd0;
            busy     <= 1'b1;
            state    <= ST_DIV60;
          end
        end
        ST_DIV60: begin
          if (work >= 8'd60) begin
            work    <= work - 8'd60;
            min_acc <= min_acc + 3'd1;
          end else begin
            sec_t_acc <= 3'd0;
            state     <= ST_DIV10;
          end
        end
        ST_DIV10: begin
          if (work >= 8'd10) begin
            work      <= work - 8'd10;
            sec_t_acc <= sec_t_acc + 3'd1;
          end else begin
            sec_o_acc <= work[3:0];
            state     <= ST_LOAD;
          end
        end
        default: begin
          disp_min_t <= 4'd0;
          disp_min_o <= {1'b0, min_acc};
          disp_sec_t <= {1'b0, sec_t_acc};
          disp_sec_o <= sec_o_acc;
          last_val   <= conv_val;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // A fresh done edge restarts the blink; a cleaning edge cancels it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_active <= 1'b0;
      done_cnt    <= '0;
      blink_on    <= 1'b0;
      blink_cnt   <= '0;
    end else if (done_rise) begin
      done_active <= 1'b1;
      done_cnt    <= DONE_W'(DONE_CYC - 1);
      blink_on    <= 1'b1;
      blink_cnt   <= BLINK_W'(BLINK_HALF - 1);
    end else if (cleaning_rise) begin
      done_active <= 1'b0;
      blink_on    <= 1'b0;
    end else if (done_active) begin
      if (done_cnt == '0) begin
        done_active <= 1'b0;
      end else begin
        done_cnt <= done_cnt - DONE_W'(1);
      end
      if (blink_cnt == '0) begin
        blink_cnt <= BLINK_W'(BLINK_HALF - 1);
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt - BLINK_W'(1);
      end
    end
  end

`ifdef COLON_BLINK_EN
  localparam int COLON_HALF = CLK_FREQ / 2;
  localparam int COLON_W    = (COLON_HALF > 1) ? $clog2(COLON_HALF) : 1;

  logic [COLON_W-1:0] colon_cnt;
  logic               colon_on;

  always_ff @(posedge clk) begin
    if (!rst) begin
      colon_cnt <= COLON_W'(COLON_HALF - 1);
      colon_on  <= 1'b1;
    end else if (cleaning_rise) begin
      colon_cnt <= COLON_W'(COLON_HALF - 1);
      colon_on  <= 1'b1;
    end else if (colon_cnt == '0) begin
      colon_cnt <= COLON_W'(COLON_HALF - 1);
      colon_on  <= ~colon_on;
    end else begin
      colon_cnt <= colon_cnt - COLON_W'(1);
    end
  end

  assign colon_lit = colon_on;
`else
  assign colon_lit = 1'b1;
`endif

  always_comb begin
    digit_val = 4'd0;
    dp_val    = 1'b0;
    case (digit_idx)
      2'd0: digit_val = disp_sec_o;
      2'd1: digit_val = disp_sec_t;
      2'd2: begin
        digit_val = disp_min_o;
        dp_val    = colon_lit;
      end
      default: digit_val = disp_min_t;
    endcase

    seg_nxt = 8'h00;
    en_nxt  = 4'b0000;
    if (done_active) begin
      if (blink_on) begin
        en_nxt  = 4'b0001 << digit_idx;
        seg_nxt = enc(4'd0) | {7'd0, (digit_idx == 2'd2)};
      end
    end else if (cleaning_q) begin
      en_nxt  = 4'b0001 << digit_idx;
      seg_nxt = enc(digit_val) | {7'd0, dp_val};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= 8'h00;
      en_q  <= 4'b0000;
    end else begin
      seg_q <= seg_nxt;
      en_q  <= en_nxt;
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.seg_en    = en_q;
  assign bus.conv_busy = busy;

endmodule

// File: tb/tb_clean_countdown_display.sv
// Directed self-checking bench for clean_countdown_display with a 4-cycle digit scan and 1 s done blink.
module tb_clean_countdown_display;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int unsigned cyc;

`ifdef COLON_BLINK_EN
  localparam bit COLON_BLINK = 1'b1;
`else
  localparam bit COLON_BLINK = 1'b0;
`endif

  clean_countdown_display_if bus ();

  clean_countdown_display #(
    .CLK_FREQ (1000),
    .SCAN_HZ  (250),
    .BLINK_HZ (2),
    .DONE_SEC (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: enc = 8'hFC;
      1: enc = 8'h60;
      2: enc = 8'hDA;
      3: enc = 8'hF2;
      4: enc = 8'h66;
      5: enc = 8'hB6;
      6: enc = 8'hBE;
      7: enc = 8'hE0;
      8: enc = 8'hFE;
      9: enc = 8'hF6;
      default: enc = 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic read_display(output logic [7:0] d0, output logic [7:0] d1,
                              output logic [7:0] d2, output logic [7:0] d3,
                              output logic ok);
    logic [3:0] seen;
    seen = 4'b0000;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    for (int i = 0; i < 24 && seen != 4'hF; i++) begin
      @(negedge clk);
      case (bus.seg_en)
        4'b0001: begin d0 = bus.seg_out; seen[0] = 1'b1; end
        4'b0010: begin d1 = bus.seg_out; seen[1] = 1'b1; end
        4'b0100: begin d2 = bus.seg_out; seen[2] = 1'b1; end
        4'b1000: begin d3 = bus.seg_out; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    ok = (seen == 4'hF);
  endtask

  task automatic check_disp(input string tag, input int mt, input int mo,
                            input int st, input int so, input logic colon);
    logic [7:0] d0, d1, d2, d3;
    logic ok;
    read_display(d0, d1, d2, d3, ok);
    chk({tag, "_scan"}, {7'd0, ok}, 8'd1);
    chk({tag, "_d0"}, d0, enc(so));
    chk({tag, "_d1"}, d1, enc(st));
    chk({tag, "_d2"}, d2, enc(mo) | {7'd0, colon});
    chk({tag, "_d3"}, d3, enc(mt));
  endtask

  // Waits for one full busy pulse, each phase bounded to 14 cycles.
  task automatic wait_conv(input string tag);
    logic seen_hi, seen_lo;
    seen_hi = bus.conv_busy;
    seen_lo = 1'b0;
    for (int i = 0; i < 14 && !seen_hi; i++) begin
      @(negedge clk);
      if (bus.conv_busy) seen_hi = 1'b1;
    end
    for (int i = 0; i < 14 && seen_hi && !seen_lo; i++) begin
      @(negedge clk);
      if (!bus.conv_busy) seen_lo = 1'b1;
    end
    chk({tag, "_busy_rise"}, {7'd0, seen_hi}, 8'd1);
    chk({tag, "_busy_fall"}, {7'd0, seen_lo}, 8'd1);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_blink_on(input string tag);
    chk({tag, "_en"}, {7'd0, (bus.seg_en != 4'b0000)}, 8'd1);
    chk({tag, "_seg"}, bus.seg_out, (bus.seg_en == 4'b0100) ? 8'hFD : 8'hFC);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_en"}, {4'd0, bus.seg_en}, 8'h00);
    chk({tag, "_seg"}, bus.seg_out, 8'h00);
  endtask

  initial begin
    int unsigned c0;
    logic [7:0] d0, d1, d2, d3;
    logic ok;
    logic exp_colon;
    checks   = 0;
    failures = 0;

    rst           = 1'b0;
    bus.cleaning  = 1'b1;
    bus.done      = 1'b0;
    bus.countdown = 8'd180;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_seg_en", {4'd0, bus.seg_en}, 8'h00);
      chk("rst_seg_out", bus.seg_out, 8'h00);
      chk("rst_busy", {7'd0, bus.conv_busy}, 8'h00);
    end
    rst = 1'b1;

    wait_conv("c180");
    check_disp("c180", 0, 3, 0, 0, 1'b1);

    bus.countdown = 8'd255;
    repeat (20) @(negedge clk);
    check_disp("c255", 0, 4, 1, 5, 1'b1);

    bus.countdown = 8'd59;
    repeat (20) @(negedge clk);
    check_disp("c59", 0, 0, 5, 9, 1'b1);

    bus.countdown = 8'd0;
    repeat (20) @(negedge clk);
    check_disp("c0", 0, 0, 0, 0, 1'b1);

    // Change input right after a conversion starts: 01:40 must land first, then 01:39.
    bus.countdown = 8'd100;
    for (int i = 0; i < 14 && !bus.conv_busy; i++) @(negedge clk);
    chk("c100_start", {7'd0, bus.conv_busy}, 8'd1);
    @(negedge clk);
    bus.countdown = 8'd99;
    for (int i = 0; i < 14 && bus.conv_busy; i++) @(negedge clk);
    chk("c100_done", {7'd0, bus.conv_busy}, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        case (bus.seg_en)
          4'b0001: chk("mid140_d0", bus.seg_out, enc(0));
          4'b0010: chk("mid140_d1", bus.seg_out, enc(4));
          4'b0100: chk("mid140_d2", bus.seg_out, enc(1) | 8'h01);
          4'b1000: chk("mid140_d3", bus.seg_out, enc(0));
          default: chk("mid140_en", {4'd0, bus.seg_en}, 8'h01);
        endcase
      end
    end
    wait_conv("c99");
    check_disp("c99", 0, 1, 3, 9, 1'b1);

    bus.cleaning  = 1'b0;
    bus.countdown = 8'd42;
    repeat (20) @(negedge clk);
    check_dark("dark_a");
    @(negedge clk);
    check_dark("dark_b");

    // Full done blink with cleaning low.
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    repeat (99) @(negedge clk);
    check_blink_on("blink_on1");
    repeat (300) @(negedge clk);
    check_dark("blink_off1");
    repeat (200) @(negedge clk);
    check_blink_on("blink_on2");
    repeat (300) @(negedge clk);
    check_dark("blink_off2");
    repeat (200) @(negedge clk);
    check_dark("blink_end_a");
    repeat (300) @(negedge clk);
    check_dark("blink_end_b");

    // Cleaning rising during the off phase must cancel the blink and show 00:42.
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    repeat (299) @(negedge clk);
    bus.cleaning = 1'b1;
    repeat (10) @(negedge clk);
    chk("cancel_en", {7'd0, (bus.seg_en != 4'b0000)}, 8'd1);
    check_disp("cancel", 0, 0, 4, 2, 1'b1);

    // Colon behaviour over 2000 cycles of ACTIVE.
    bus.cleaning = 1'b0;
    repeat (5) @(negedge clk);
    bus.cleaning = 1'b1;
    c0 = cyc;
    for (int p = 0; p < 4; p++) begin
      wait_until(c0 + 240 + 500 * p);
      exp_colon = COLON_BLINK ? ((p % 2) == 0) : 1'b1;
      read_display(d0, d1, d2, d3, ok);
      chk("colon_scan", {7'd0, ok}, 8'd1);
      chk("colon_d0", d0, enc(2));
      chk("colon_d1", d1, enc(4));
      chk("colon_d2", d2, enc(0) | {7'd0, exp_colon});
      chk("colon_d3", d3, enc(0));
    end

    rst = 1'b0;
    @(negedge clk);
    chk("rst2_seg_en", {4'd0, bus.seg_en}, 8'h00);
    chk("rst2_busy", {7'd0, bus.conv_busy}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
